// File: rtl/seed_frame_loader_if.sv
// Host-word and cipher-core handshake bundle for the seed frame loader.
// The slave modport is the loader's view; master is the host/core side.
interface seed_frame_loader_if;
  logic         i_fValid;
  logic [31:0]  i_Word;
  logic         i_fNewKey;
  logic         o_fReady;
  logic [128:0] o_Data;
  logic         i_fDone;
  logic [127:0] i_Text;
  logic [127:0] o_Result;
  logic         o_fResultValid;
  logic         o_fErr;

  modport slave (
    input  i_fValid, i_Word, i_fNewKey, i_fDone, i_Text,
    output o_fReady, o_Data, o_Result, o_fResultValid, o_fErr
  );

  modport master (
    output i_fValid, i_Word, i_fNewKey, i_fDone, i_Text,
    input  o_fReady, o_Data, o_Result, o_fResultValid, o_fErr
  );
endinterface

// File: rtl/seed_frame_loader.sv
// Collects 32-bit host words into key/text frames, launches the cipher core
// and captures its result, with a timeout guarding the wait for completion.
module seed_frame_loader #(
  parameter int BUSY_MAX = 255
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  seed_frame_loader_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOADKEY  = 3'd1,
    LOADTEXT = 3'd2,
    LAUNCH   = 3'd3,
    PRESENT  = 3'd4,
    BUSY     = 3'd5
  } state_t;

  localparam logic [9:0] BUSY_LIMIT = 10'(BUSY_MAX);

  state_t         state_r;
  logic [127:0]   shift_r;
  logic [127:0]   key_r;
  logic [1:0]     word_cnt_r;
  logic [9:0]     busy_cnt_r;
  logic           key_loaded_r;
  logic           ready_r;
  logic [128:0]   data_r;
  logic [127:0]   result_r;
  logic           result_valid_r;
  logic           err_r;

  logic           take_s;
  logic [127:0]   shift_next_s;
  logic           busy_last_s;

  assign take_s       = bus.i_fValid & ready_r;
  assign shift_next_s = {shift_r[95:0], bus.i_Word};
  // True in the BUSY cycle in which the budget is used up.
  assign busy_last_s  = ((busy_cnt_r + 10'd1) == BUSY_LIMIT);

  assign bus.o_fReady       = ready_r;
  assign bus.o_Data         = data_r;
  assign bus.o_Result       = result_r;
  assign bus.o_fResultValid = result_valid_r;
  assign bus.o_fErr         = err_r;

  // Frame-loading and launch FSM; ready_r tracks the accepting states.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_r        <= IDLE;
      shift_r        <= 128'd0;
      key_r          <= 128'd0;
      word_cnt_r     <= 2'd0;
      busy_cnt_r     <= 10'd0;
      key_loaded_r   <= 1'b0;
      ready_r        <= 1'b1;
      data_r         <= 129'd0;
      result_r       <= 128'd0;
      result_valid_r <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      result_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (take_s) begin
            if (bus.i_fNewKey) begin
              shift_r    <= shift_next_s;
              word_cnt_r <= 2'd1;
              state_r    <= LOADKEY;
            end else if (key_loaded_r) begin
              shift_r    <= shift_next_s;
              word_cnt_r <= 2'd1;
              state_r    <= LOADTEXT;
            end else begin
              // Text-only frame with no key ever loaded: drop the word.
              err_r <= 1'b1;
            end
          end
        end
        LOADKEY: begin
          if (take_s) begin
            shift_r    <= shift_next_s;
            word_cnt_r <= word_cnt_r + 2'd1;
            if (word_cnt_r == 2'd3) begin
              key_r        <= shift_next_s;
              key_loaded_r <= 1'b1;
              state_r      <= LOADTEXT;
            end
          end
        end
        LOADTEXT: begin
          if (take_s) begin
            shift_r    <= shift_next_s;
            word_cnt_r <= word_cnt_r + 2'd1;
            if (word_cnt_r == 2'd3) begin
              state_r <= LAUNCH;
              ready_r <= 1'b0;
              data_r  <= {1'b1, key_r};
            end
          end
        end
        LAUNCH: begin
          state_r <= PRESENT;
          data_r  <= {1'b0, shift_r};
        end
        PRESENT: begin
          state_r    <= BUSY;
          busy_cnt_r <= 10'd0;
        end
        BUSY: begin
          // A done in the final budget cycle still wins over the timeout.
          if (bus.i_fDone) begin
            result_r       <= bus.i_Text;
            result_valid_r <= 1'b1;
            state_r        <= IDLE;
            ready_r        <= 1'b1;
            data_r         <= 129'd0;
          end else if (busy_last_s) begin
            err_r   <= 1'b1;
            state_r <= IDLE;
            ready_r <= 1'b1;
            data_r  <= 129'd0;
          end else begin
            busy_cnt_r <= busy_cnt_r + 10'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          data_r  <= 129'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seed_frame_loader.sv
// Scoreboard bench for seed_frame_loader: a frame-level model predicts launches
// and results into queues; a negedge monitor pops and compares them.
module tb_seed_frame_loader;
  localparam int BUSY_MAX = 16;

  logic clk = 1'b0;
  logic rst;

  seed_frame_loader_if bus ();

  seed_frame_loader #(.BUSY_MAX(BUSY_MAX)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [255:0] launch_q[$];
  logic [127:0] result_q[$];

  bit           model_key_loaded;
  logic [127:0] model_key;
  bit           model_err;

  bit           present_pend;
  logic [127:0] pend_text;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  // Monitor: compares every launch strobe, present cycle and result pulse.
  always @(negedge clk) begin
    logic [255:0] e;
    if (rst) begin
      present_pend = 1'b0;
    end else begin
      if (present_pend) begin
        check("present_data", 256'(bus.o_Data), 256'({1'b0, pend_text}));
        present_pend = 1'b0;
      end
      if (bus.o_Data[128]) begin
        if (launch_q.size() == 0) begin
          flag_fail("unexpected_launch");
        end else begin
          e = launch_q.pop_front();
          check("launch_data", 256'(bus.o_Data), 256'({1'b1, e[255:128]}));
          pend_text    = e[127:0];
          present_pend = 1'b1;
        end
      end
      if (bus.o_fResultValid) begin
        if (result_q.size() == 0) begin
          flag_fail("unexpected_result");
        end else begin
          check("result", 256'(bus.o_Result), 256'(result_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_outputs",
          256'({bus.o_Data, bus.o_fResultValid, bus.o_fErr, bus.o_fReady}),
          256'({129'd0, 1'b0, 1'b0, 1'b1}));
    check("reset_result", 256'(bus.o_Result), 256'd0);
    tick();
    tick();
    rst = 1'b0;
    model_err        = 1'b0;
    model_key_loaded = 1'b0;
  endtask

  // Offers one word, optionally after a valid-low gap, until it is accepted.
  task automatic send_word(input logic [31:0] w, input bit nk, input int gap);
    bit r;
    int n;
    bus.i_fValid = 1'b0;
    repeat (gap) tick();
    bus.i_fValid  = 1'b1;
    bus.i_Word    = w;
    bus.i_fNewKey = nk;
    n = 0;
    forever begin
      r = bus.o_fReady;
      tick();
      if (r) break;
      n++;
      if (n > 64) begin
        flag_fail("ready_timeout");
        break;
      end
    end
    bus.i_fValid  = 1'b0;
    bus.i_fNewKey = 1'b0;
  endtask

  // done_at >= 0: done in that BUSY cycle; -1: let it time out; -2: return in BUSY.
  task automatic run_frame(input bit nk, input logic [127:0] key, input logic [127:0] text,
                           input int max_gap, input int done_at);
    logic [127:0] res;
    if (nk) begin
      for (int i = 0; i < 4; i++)
        send_word(key[127 - 32*i -: 32], (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                  $urandom_range(0, max_gap));
    end
    for (int i = 0; i < 4; i++)
      send_word(text[127 - 32*i -: 32], (i == 0 && !nk) ? 1'b0 : 1'($urandom_range(0, 1)),
                $urandom_range(0, max_gap));
    if (nk) begin
      model_key        = key;
      model_key_loaded = 1'b1;
    end
    launch_q.push_back({model_key, text});
    check("launch_latency", 256'({bus.o_Data[128], bus.o_fReady}), 256'(2'b10));
    bus.i_fDone = 1'($urandom_range(0, 1));
    bus.i_Text  = rand128();
    tick();
    bus.i_fDone = 1'b0;
    tick();
    if (done_at == -2) return;
    if (done_at >= 0) begin
      repeat (done_at) tick();
      res = rand128();
      check("busy_hold", 256'(bus.o_Data), 256'({1'b0, text}));
      bus.i_fDone = 1'b1;
      bus.i_Text  = res;
      result_q.push_back(res);
      tick();
      bus.i_fDone = 1'b0;
      check("after_done", 256'({bus.o_fReady, bus.o_Data}), 256'({1'b1, 129'd0}));
    end else begin
      repeat (BUSY_MAX - 1) tick();
      check("busy_last_cycle", 256'({bus.o_fErr, bus.o_fReady}), 256'({model_err, 1'b0}));
      tick();
      model_err = 1'b1;
      check("timeout", 256'({bus.o_fErr, bus.o_fReady, bus.o_Data}), 256'({2'b11, 129'd0}));
    end
    check("err_flag", 256'(bus.o_fErr), 256'(model_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k;
    logic [127:0] t;
    int d;
    bit nk;
    rst           = 1'b1;
    bus.i_fValid  = 1'b0;
    bus.i_Word    = 32'd0;
    bus.i_fNewKey = 1'b0;
    bus.i_fDone   = 1'b0;
    bus.i_Text    = 128'd0;
    tick();
    do_reset();

    // Text-only word straight after reset is dropped and flags an error.
    send_word(32'hDEADBEEF, 1'b0, 0);
    check("nokey_drop", 256'({bus.o_fErr, bus.o_fReady, bus.o_Data}), 256'({2'b11, 129'd0}));
    tick();
    check("nokey_hold", 256'({bus.o_fReady, bus.o_Data}), 256'({1'b1, 129'd0}));
    do_reset();

    // Directed key+text frame and result capture.
    run_frame(1'b1, 128'h000102030405060708090A0B0C0D0E0F,
              128'h11111111222222223333333344444444, 0, 3);
    // Text-only frame reuses the stored key; done on the last budget cycle.
    run_frame(1'b0, 128'h0, 128'h55555555666666667777777788888888, 0, BUSY_MAX - 1);
    // Timeout with no done.
    run_frame(1'b0, 128'h0, 128'h99999999AAAAAAAABBBBBBBBCCCCCCCC, 1, -1);
    do_reset();

    // Stall pattern 1,0,0,1 then reset after the 6th word.
    send_word(32'h00010203, 1'b1, 0);
    send_word(32'h04050607, 1'b0, 0);
    send_word(32'h08090A0B, 1'b0, 2);
    send_word(32'h0C0D0E0F, 1'b0, 0);
    send_word(32'h11111111, 1'b1, 0);
    bus.i_fValid = 1'b0;
    repeat (3) tick();
    check("stall_hold", 256'({bus.o_fReady, bus.o_Data}), 256'({1'b1, 129'd0}));
    send_word(32'h22222222, 1'b0, 0);
    do_reset();
    run_frame(1'b1, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF,
              128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF, 0, 0);

    // Reset while BUSY discards the frame; next frame starts from word 0.
    run_frame(1'b0, 128'h0, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 0, -2);
    tick();
    do_reset();

    // Randomised frames against the frame-level model.
    for (int f = 0; f < 14; f++) begin
      nk = !model_key_loaded || ($urandom_range(0, 2) == 0);
      k  = rand128();
      t  = rand128();
      d  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, BUSY_MAX - 1));
      run_frame(nk, k, t, 2, d);
    end

    tick();
    tick();
    check("queues_empty", 256'(launch_q.size() + result_q.size()), 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seed_frame_loader.md
SEED_FRAME_LOADER -- requirements
Module: seed_frame_loader

Interface
REQ-001 Parameter BUSY_MAX, default 255: cycle budget while waiting for i_fDone before the timeout error is raised (range 16..1023).
REQ-002 i_Clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 i_Rst  in  1  asynchronous, active-high reset.
REQ-004 i_fValid  in  1  host word valid.
REQ-005 i_Word  in  32  host data word, most-significant word first.
REQ-006 i_fNewKey  in  1  sampled with the first word of a frame: 1 = 4 key words then 4 text words; 0 = 4 text words only, stored key reused.
REQ-007 o_fReady  out  1  loader can accept a word this cycle.
REQ-008 o_Data  out  129  cipher-core input: bit 128 = start strobe, bits 127:0 = key or text.
REQ-009 i_fDone  in  1  cipher-core done pulse.
REQ-010 i_Text  in  128  cipher-core result, valid while i_fDone = 1.
REQ-011 o_Result  out  128  captured cipher result.
REQ-012 o_fResultValid  out  1  one-cycle pulse, o_Result updated.
REQ-013 o_fErr  out  1  sticky error flag.

Function
REQ-014 The block SHALL implement states IDLE, LOADKEY, LOADTEXT, LAUNCH, PRESENT, BUSY.
REQ-015 A word SHALL transfer only in a cycle where i_fValid = 1 and o_fReady = 1; o_fReady SHALL be 1 only in IDLE, LOADKEY and LOADTEXT.
REQ-016 In IDLE, a transfer SHALL store the word as word 0 and go to LOADKEY if i_fNewKey = 1, else to LOADTEXT; i_fNewKey SHALL be ignored on the other words.
REQ-017 In IDLE with i_fNewKey = 0 and no key loaded since reset, the transfer SHALL be dropped, o_fErr set, and the state SHALL stay IDLE.
REQ-018 Words SHALL shift into a 128-bit register from the LSB end, so the first word ends in bits 127:96; a 2-bit counter SHALL count words and wrap after the 4th.
REQ-019 After the 4th key word the key register SHALL load, the key-loaded flag SHALL set, and the state SHALL go to LOADTEXT with the word counter at 0.
REQ-020 After the 4th text word the state SHALL go to LAUNCH on the next edge.
REQ-021 LAUNCH SHALL last exactly one cycle with o_Data = {1'b1, key}.
REQ-022 PRESENT SHALL last exactly one cycle with o_Data = {1'b0, text}, then go to BUSY.
REQ-023 In BUSY, o_Data SHALL hold {1'b0, text}; in all other states o_Data SHALL be 0.
REQ-024 Latency: the 4th text word accepted on edge N gives LAUNCH in cycle N+1 and PRESENT in cycle N+2.
REQ-025 In BUSY, i_fDone = 1 SHALL capture i_Text into o_Result, pulse o_fResultValid in the next cycle, and return to IDLE.
REQ-026 A 10-bit busy counter SHALL clear on entry to BUSY and increment each BUSY cycle; on reaching BUSY_MAX without i_fDone, o_fErr SHALL set, the state SHALL go to IDLE, and no result SHALL be flagged.
REQ-027 i_fDone SHALL be ignored outside BUSY; i_fDone in the same cycle the counter reaches BUSY_MAX SHALL count as success.
REQ-028 If i_fValid is deasserted mid-frame, the state and partial words SHALL be held indefinitely.
REQ-029 o_fErr SHALL clear only on reset.

Reset
REQ-030 Asserting i_Rst SHALL immediately force IDLE, counters 0, key-loaded flag 0, and o_Data, o_Result, o_fResultValid and o_fErr to 0; o_fReady SHALL be 1 after reset.
REQ-031 Reset asserted mid-frame or in BUSY SHALL discard the partial frame, and the first word after release SHALL be treated as word 0.

Verification
REQ-032 Reset, then 8 back-to-back words 00010203, 04050607, 08090A0B, 0C0D0E0F (key) and 11111111..44444444 (text) with i_fNewKey = 1 -> one-cycle o_Data = {1, 000102030405060708090A0B0C0D0E0F}, then {0, 11111111222222223333333344444444} held until done.
REQ-033 From REQ-032, i_fDone = 1 with i_Text = FFEEDDCC...00 in BUSY -> o_Result = that value, o_fResultValid high exactly one cycle, o_fReady = 1 afterwards.
REQ-034 Second frame of 4 words with i_fNewKey = 0 -> LAUNCH carries the key from REQ-032 unchanged.
REQ-035 Word with i_fNewKey = 0 immediately after reset -> no state change, o_fErr = 1, o_Data = 0.
REQ-036 BUSY_MAX = 16 and no i_fDone -> o_fErr rises after 16 BUSY cycles, no o_fResultValid, return to IDLE.
REQ-037 i_fValid toggled 1,0,0,1 during loading, plus reset asserted after the 6th word -> stalls hold; after reset, a new 8-word frame produces the correct o_Data.
